aim_control_multi: RTL and testbench

- Parametrised successor to the launcher's aim/power arrow block for the ball-thrower game.
- Keeps an angle index and a power index, both saturating. Buttons are active-low; a held button steps once, then auto-repeats at a frame-based rate.
- Derives the arrow sprite position from the two indices and produces the arrow overlay pixel for the VGA mixer.
- Runs entirely in the clk domain. Updates are qualified by a one-cycle frame_tick strobe rather than a separate update clock.

---
 rtl/aim_pkg.sv | 15 +
 rtl/btn_repeat.sv | 69 ++++++
 rtl/aim_control_multi.sv | 87 ++++++++
 tb/tb_aim_control_multi.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// aim_pkg: direction codes, FSM states, screen limits and arrow position helper shared by the aim block.
package aim_pkg;
    localparam logic [1:0] DIR_ANG_UP = 2'd0;
    localparam logic [1:0] DIR_ANG_DN = 2'd1;
    localparam logic [1:0] DIR_PWR_UP = 2'd2;
    localparam logic [1:0] DIR_PWR_DN = 2'd3;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    typedef enum logic {IDLE, HELD} state_t;
    function automatic logic [9:0] lin(input int o, input int v, input int dv, input int a, input int da);
        logic [10:0] s;
        s = 11'(o + v * dv + a * da);
        return s[9:0];
    endfunction
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: synchronizes four active-low buttons, picks the highest-priority press and auto-repeats it on frame ticks.
module btn_repeat
    import aim_pkg::*;
#(
    parameter int REPEAT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_tick,
    input  logic       i_lock,
    input  logic [3:0] i_btn_n,
    output logic       o_step,
    output logic [1:0] o_dir
);
    localparam int CW = REPEAT_TICKS > 1 ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_TICKS - 1);
    logic [3:0]    r_s1, r_s2;
    logic [3:0]    w_pressed;
    logic [1:0]    r_dir, w_dir, w_pri;
    logic [CW-1:0] r_cnt, w_cnt;
    state_t        r_state, w_state;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '1;
            r_s2    <= '1;
            r_state <= IDLE;
            r_dir   <= DIR_ANG_UP;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn_n;
            r_s2    <= r_s1;
            r_state <= w_state;
            r_dir   <= w_dir;
            r_cnt   <= w_cnt;
        end
    end
    assign w_pressed = ~r_s2;
    assign w_pri = w_pressed[0] ? DIR_ANG_UP : w_pressed[1] ? DIR_ANG_DN :
                   w_pressed[2] ? DIR_PWR_UP : DIR_PWR_DN;
    // lock overrides everything, including a coincident frame tick
    always_comb begin
        w_state = r_state;
        w_dir   = r_dir;
        w_cnt   = r_cnt;
        o_step  = 1'b0;
        if (i_lock) begin
            w_state = IDLE;
            w_cnt   = '0;
        end else if (i_frame_tick) begin
            if (r_state == IDLE) begin
                if (|w_pressed) begin
                    o_step  = 1'b1;
                    w_dir   = w_pri;
                    w_cnt   = '0;
                    w_state = HELD;
                end
            end else if (!w_pressed[r_dir]) begin
                w_state = IDLE;
                w_cnt   = '0;
            end else if (r_cnt == CNT_LAST) begin
                o_step = 1'b1;
                w_cnt  = '0;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        end
    end
    assign o_dir = w_dir;
endmodule

// File: rtl/aim_control_multi.sv
// aim_control_multi: saturating angle/power indices driven by repeating buttons, arrow sprite position and overlay pixel.
module aim_control_multi
    import aim_pkg::*;
#(
    parameter int ANG_W        = 5,
    parameter int PWR_W        = 3,
    parameter int ANG_MAX      = 20,
    parameter int PWR_MAX      = 7,
    parameter int ANG_INIT     = 0,
    parameter int PWR_INIT     = 0,
    parameter int REPEAT_TICKS = 8,
    parameter int ORIGIN_X     = 31,
    parameter int ORIGIN_Y     = 443,
    parameter int ANG_DX       = 1,
    parameter int ANG_DY       = 4,
    parameter int PWR_DX       = 4,
    parameter int PWR_DY       = 10,
    parameter int ARROW_SIZE   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             lock,
    input  logic             angleup_n,
    input  logic             angledown_n,
    input  logic             powerup_n,
    input  logic             powerdown_n,
    input  logic [9:0]       xCount,
    input  logic [9:0]       yCount,
    output logic [ANG_W-1:0] Ang,
    output logic [PWR_W-1:0] Vel,
    output logic [9:0]       arrow_x,
    output logic [9:0]       arrow_y,
    output logic             arrow,
    output logic             aim_changed
);
    localparam logic [ANG_W-1:0] A_MAX  = ANG_W'(ANG_MAX);
    localparam logic [ANG_W-1:0] A_INIT = ANG_W'(ANG_INIT);
    localparam logic [PWR_W-1:0] P_MAX  = PWR_W'(PWR_MAX);
    localparam logic [PWR_W-1:0] P_INIT = PWR_W'(PWR_INIT);
    logic             w_step;
    logic [1:0]       w_dir;
    logic [ANG_W-1:0] r_ang, w_ang;
    logic [PWR_W-1:0] r_vel, w_vel;
    logic [9:0]       r_ax, r_ay;
    logic [10:0]      w_xe, w_ye;
    logic             r_arrow, r_changed;
    btn_repeat #(.REPEAT_TICKS(REPEAT_TICKS)) u_btn (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (frame_tick),
        .i_lock       (lock),
        .i_btn_n      ({powerdown_n, powerup_n, angledown_n, angleup_n}),
        .o_step       (w_step),
        .o_dir        (w_dir)
    );
    assign w_ang = (w_step && w_dir == DIR_ANG_UP && r_ang != A_MAX) ? r_ang + 1'b1 :
                   (w_step && w_dir == DIR_ANG_DN && r_ang != '0)    ? r_ang - 1'b1 : r_ang;
    assign w_vel = (w_step && w_dir == DIR_PWR_UP && r_vel != P_MAX) ? r_vel + 1'b1 :
                   (w_step && w_dir == DIR_PWR_DN && r_vel != '0)    ? r_vel - 1'b1 : r_vel;
    assign w_xe = {1'b0, r_ax} + 11'(ARROW_SIZE);
    assign w_ye = {1'b0, r_ay} + 11'(ARROW_SIZE);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ang     <= A_INIT;
            r_vel     <= P_INIT;
            r_changed <= 1'b0;
            r_arrow   <= 1'b0;
            r_ax      <= lin(ORIGIN_X, PWR_INIT, PWR_DX, ANG_INIT, -ANG_DX);
            r_ay      <= lin(ORIGIN_Y, PWR_INIT, -PWR_DY, ANG_INIT, -ANG_DY);
        end else begin
            r_ang     <= w_ang;
            r_vel     <= w_vel;
            r_changed <= (w_ang != r_ang) || (w_vel != r_vel);
            r_ax      <= lin(ORIGIN_X, int'(r_vel), PWR_DX, int'(r_ang), -ANG_DX);
            r_ay      <= lin(ORIGIN_Y, int'(r_vel), -PWR_DY, int'(r_ang), -ANG_DY);
            r_arrow   <= (xCount > r_ax) && ({1'b0, xCount} < w_xe) &&
                         (yCount > r_ay) && ({1'b0, yCount} < w_ye);
        end
    end
    assign Ang         = r_ang;
    assign Vel         = r_vel;
    assign arrow_x     = r_ax;
    assign arrow_y     = r_ay;
    assign arrow       = r_arrow;
    assign aim_changed = r_changed;
endmodule

// File: tb/tb_aim_control_multi.sv
// tb_aim_control_multi: directed checks of stepping, repeat, saturation, priority, lock, reset and arrow pixel.
module tb_aim_control_multi;
    logic       clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, lock = 1'b0;
    logic [3:0] bn = 4'hF;
    logic       pu1 = 1'b1;
    logic [9:0] xc = '0, yc = '0;
    logic [4:0] ang0, ang1;
    logic [2:0] vel0, vel1;
    logic [9:0] ax0, ay0, ax1, ay1;
    logic       arw0, arw1, chg0, chg1;
    int total = 0, bad = 0, pulses0 = 0, pulses1 = 0;

    aim_control_multi dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .lock(lock),
        .angleup_n(bn[0]), .angledown_n(bn[1]), .powerup_n(bn[2]), .powerdown_n(bn[3]),
        .xCount(xc), .yCount(yc), .Ang(ang0), .Vel(vel0), .arrow_x(ax0), .arrow_y(ay0),
        .arrow(arw0), .aim_changed(chg0)
    );
    aim_control_multi #(.REPEAT_TICKS(1)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .lock(lock),
        .angleup_n(1'b1), .angledown_n(1'b1), .powerup_n(pu1), .powerdown_n(1'b1),
        .xCount(xc), .yCount(yc), .Ang(ang1), .Vel(vel1), .arrow_x(ax1), .arrow_y(ay1),
        .arrow(arw1), .aim_changed(chg1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chg0 === 1'b1) pulses0++;
        if (chg1 === 1'b1) pulses1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic tap(input int i);
        bn[i] = 1'b0;
        tick();
        bn[i] = 1'b1;
        tick();
    endtask

    initial begin
        int p0, p1, ones;
        logic prev, exp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ang", ang0, 0);
        chk("rst_vel", vel0, 0);
        chk("rst_ax", ax0, 31);
        chk("rst_ay", ay0, 443);
        chk("rst_arrow", arw0, 0);
        chk("rst_chg", chg0, 0);
        p0 = pulses0;
        repeat (3) tick();
        chk("idle_ang", ang0, 0);
        chk("idle_vel", vel0, 0);
        chk("idle_ax", ax0, 31);
        chk("idle_ay", ay0, 443);
        chk("idle_pulses", pulses0 - p0, 0);

        ones = 0;
        prev = 1'b0;
        for (int y = 440; y <= 456; y++) begin
            for (int x = 28; x <= 44; x++) begin
                @(negedge clk);
                xc = 10'(x);
                yc = 10'(y);
                chk("arrow_lat", arw0, prev);
                @(posedge clk);
                #1;
                exp = (x >= 32 && x <= 40 && y >= 444 && y <= 452);
                chk("arrow_px", arw0, exp);
                prev = exp;
                ones += int'(exp);
            end
        end
        chk("arrow_count", ones, 81);

        p1 = pulses1;
        pu1 = 1'b0;
        repeat (10) tick();
        chk("rep1_vel", vel1, 7);
        chk("rep1_ang", ang1, 0);
        chk("rep1_pulses", pulses1 - p1, 7);
        chk("rep1_ax", ax1, 59);
        chk("rep1_ay", ay1, 373);
        pu1 = 1'b1;
        tick();

        p0 = pulses0;
        bn[0] = 1'b0;
        repeat (8) tick();
        chk("hold_t8", ang0, 1);
        repeat (8) tick();
        chk("hold_t16", ang0, 2);
        tick();
        chk("hold_t17", ang0, 3);
        chk("hold_pulses", pulses0 - p0, 3);
        chk("hold_ax", ax0, 28);
        chk("hold_ay", ay0, 431);
        bn[0] = 1'b1;
        tick();

        tap(1);
        tap(2);
        tap(2);
        tap(2);
        chk("prep_ang", ang0, 2);
        chk("prep_vel", vel0, 3);
        p0 = pulses0;
        bn[0] = 1'b0;
        bn[3] = 1'b0;
        tick();
        chk("pri_ang", ang0, 3);
        chk("pri_vel", vel0, 3);
        bn[0] = 1'b1;
        tick();
        chk("rel_vel", vel0, 3);
        tick();
        chk("pd_vel", vel0, 2);
        chk("pd_ang", ang0, 3);
        chk("pri_pulses", pulses0 - p0, 2);
        bn[3] = 1'b1;
        tick();

        lock = 1'b1;
        bn[1] = 1'b0;
        repeat (20) tick();
        chk("lock_ang", ang0, 3);
        lock = 1'b0;
        tick();
        chk("unlock_ang", ang0, 2);
        chk("pos_ax", ax0, 37);
        chk("pos_ay", ay0, 415);
        bn[1] = 1'b1;
        tick();

        bn[0] = 1'b0;
        tick();
        chk("mid_ang", ang0, 3);
        repeat (4) tick();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ang", ang0, 0);
        chk("midrst_vel", vel0, 0);
        chk("midrst_ax", ax0, 31);
        tick();
        chk("fresh_ang", ang0, 1);
        bn[0] = 1'b1;
        tick();

        p0 = pulses0;
        tap(1);
        tap(1);
        chk("sat0_ang", ang0, 0);
        chk("sat0_pulses", pulses0 - p0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
